restoring_div_unsigned: RTL and testbench

- Multi-cycle unsigned restoring divider, one quotient bit per cycle.
- Sits directly downstream of the contrast-stretch multiplier.
- Takes the 2*DATA_WIDTH-bit product, (pixel-min)*255, as dividend and (max-min) as divisor.
- Produces the stretched pixel value as quotient, plus remainder and status.

---
 rtl/restoring_div_unsigned_if.sv | 24 ++
 rtl/restoring_div_unsigned.sv | 131 +++++++++++++
 tb/tb_restoring_div_unsigned.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/restoring_div_unsigned_if.sv
// Operand/result bundle for the restoring divider.
// The master side issues operands and a start request; the slave side returns results.
interface restoring_div_unsigned_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      en_i_div;
    logic [2*DATA_WIDTH-1:0]   dividend_i;
    logic [DATA_WIDTH-1:0]     divisor_i;
    logic [2*DATA_WIDTH-1:0]   quotient_o;
    logic [DATA_WIDTH-1:0]     remainder_o;
    logic                      div_by_zero_o;
    logic                      busy_o;
    logic                      div_done_o;

    modport master (
        output en_i_div, dividend_i, divisor_i,
        input  quotient_o, remainder_o, div_by_zero_o, busy_o, div_done_o
    );

    modport slave (
        input  en_i_div, dividend_i, divisor_i,
        output quotient_o, remainder_o, div_by_zero_o, busy_o, div_done_o
    );
endinterface

// File: rtl/restoring_div_unsigned.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle (2*DATA_WIDTH iterations).
// Optional macro DIV_ROUND_EN: round-to-nearest (ties up, saturating) on the final quotient.
module restoring_div_unsigned #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk_i_div,
    input  logic                     rstn_i_div,
    restoring_div_unsigned_if.slave  div_if
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(2*W+1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP   = 2'd1,
        S_LAST = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [2*W-1:0]   r_q, w_q_next;
    logic [W-1:0]     r_d, w_d_next;
    logic [W:0]       r_r, w_r_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [2*W-1:0]   r_quotient, w_quotient_next;
    logic [W-1:0]     r_remainder, w_remainder_next;
    logic             r_dbz, w_dbz_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;

    // One restoring step on the concatenated {R,Q} register.
    logic [W:0]       w_r_shift;
    logic             w_sub_ok;
    logic [W:0]       w_r_iter;
    logic [2*W-1:0]   w_q_iter;
    logic [2*W-1:0]   w_q_final;
    logic             w_d_zero;

    assign w_r_shift = {r_r[W-1:0], r_q[2*W-1]};
    // A set R MSB means the shifted value already exceeds any W-bit divisor.
    assign w_sub_ok  = r_r[W] | (w_r_shift >= {1'b0, r_d});
    assign w_r_iter  = w_sub_ok ? (w_r_shift - {1'b0, r_d}) : w_r_shift;
    assign w_q_iter  = {r_q[2*W-2:0], w_sub_ok};
    assign w_d_zero  = (r_d == '0);

`ifdef DIV_ROUND_EN
    logic w_round_up;
    assign w_round_up = ({r_r, 1'b0} >= {2'b00, r_d});
    assign w_q_final  = (w_round_up && (r_q != '1)) ? (r_q + 1'b1) : r_q;
`else
    assign w_q_final  = r_q;
`endif

    always_ff @(posedge clk_i_div or negedge rstn_i_div) begin
        if (!rstn_i_div) begin
            r_state     <= S_IDLE;
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_q         <= w_q_next;
            r_d         <= w_d_next;
            r_r         <= w_r_next;
            r_cnt       <= w_cnt_next;
            r_quotient  <= w_quotient_next;
            r_remainder <= w_remainder_next;
            r_dbz       <= w_dbz_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_q_next         = r_q;
        w_d_next         = r_d;
        w_r_next         = r_r;
        w_cnt_next       = r_cnt;
        w_quotient_next  = r_quotient;
        w_remainder_next = r_remainder;
        w_dbz_next       = r_dbz;
        w_busy_next      = r_busy;
        w_done_next      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // busy drops here on the edge after the done pulse unless a new start arrives.
                w_busy_next = div_if.en_i_div;
                if (div_if.en_i_div) begin
                    w_q_next     = div_if.dividend_i;
                    w_d_next     = div_if.divisor_i;
                    w_r_next     = '0;
                    w_cnt_next   = '0;
                    w_state_next = S_OP;
                end
            end
            S_OP: begin
                w_q_next   = w_q_iter;
                w_r_next   = w_r_iter;
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == CW'(2*W-1)) begin
                    w_state_next = S_LAST;
                end
            end
            S_LAST: begin
                w_quotient_next  = w_d_zero ? '1 : w_q_final;
                w_remainder_next = w_d_zero ? '0 : r_r[W-1:0];
                w_dbz_next       = w_d_zero;
                w_done_next      = 1'b1;
                w_busy_next      = 1'b1;
                w_state_next     = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign div_if.quotient_o    = r_quotient;
    assign div_if.remainder_o   = r_remainder;
    assign div_if.div_by_zero_o = r_dbz;
    assign div_if.busy_o        = r_busy;
    assign div_if.div_done_o    = r_done;

endmodule

// File: tb/tb_restoring_div_unsigned.sv
// Scoreboard bench for restoring_div_unsigned: driver queues hand-computed results,
// a negedge monitor pops and compares on every div_done_o pulse.
module tb_restoring_div_unsigned;
    localparam int W       = 8;
    localparam int LATENCY = 2*W + 1;

    typedef struct {
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           dbz;
        int             start;
    } exp_t;

    logic clk;
    logic rstn;
    int   total;
    int   bad;
    int   cyc;
    logic prev_done;
    exp_t sb[$];

    restoring_div_unsigned_if #(.DATA_WIDTH(W)) dif ();

    restoring_div_unsigned #(.DATA_WIDTH(W)) dut (
        .clk_i_div  (clk),
        .rstn_i_div (rstn),
        .div_if     (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: compare each completion against the oldest queued expectation.
    initial prev_done = 1'b0;
    always @(negedge clk) begin
        if (dif.div_done_o === 1'b1) begin
            exp_t e;
            chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 required=0 q=%0d", dif.quotient_o);
            end else begin
                e = sb.pop_front();
                chk("quotient", {16'd0, dif.quotient_o}, {16'd0, e.q});
                chk("remainder", {24'd0, dif.remainder_o}, {24'd0, e.r});
                chk("div_by_zero", {31'd0, dif.div_by_zero_o}, {31'd0, e.dbz});
                chk("latency", cyc - e.start, LATENCY);
                $display("txn q=%0d r=%0d dbz=%0d latency=%0d", dif.quotient_o,
                         dif.remainder_o, dif.div_by_zero_o, cyc - e.start);
            end
        end
        prev_done = dif.div_done_o;
    end

    function automatic logic [2*W-1:0] pick_q(input logic [2*W-1:0] q_trunc,
                                              input logic [2*W-1:0] q_round);
`ifdef DIV_ROUND_EN
        return q_round;
`else
        return q_trunc;
`endif
    endfunction

    task automatic push_exp(input logic [2*W-1:0] qt, input logic [2*W-1:0] qr,
                            input logic [W-1:0] r, input logic dbz);
        exp_t e;
        e.q     = pick_q(qt, qr);
        e.r     = r;
        e.dbz   = dbz;
        e.start = cyc;
        sb.push_back(e);
    endtask

    task automatic start_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                            input logic [2*W-1:0] qt, input logic [2*W-1:0] qr,
                            input logic [W-1:0] r, input logic dbz);
        @(negedge clk);
        dif.en_i_div   = 1'b1;
        dif.dividend_i = dvd;
        dif.divisor_i  = dvs;
        @(posedge clk);
        #1;
        push_exp(qt, qr, r, dbz);
        dif.en_i_div = 1'b0;
        chk("busy_after_start", {31'd0, dif.busy_o}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || dif.busy_o === 1'b1) && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0 || dif.busy_o === 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_timeout actual=pending%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic [2*W-1:0] qt, input logic [2*W-1:0] qr,
                       input logic [W-1:0] r, input logic dbz);
        start_op(dvd, dvs, qt, qr, r, dbz);
        wait_idle();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_quotient"}, {16'd0, dif.quotient_o}, 32'd0);
        chk({name, "_remainder"}, {24'd0, dif.remainder_o}, 32'd0);
        chk({name, "_dbz"}, {31'd0, dif.div_by_zero_o}, 32'd0);
        chk({name, "_busy"}, {31'd0, dif.busy_o}, 32'd0);
        chk({name, "_done"}, {31'd0, dif.div_done_o}, 32'd0);
    endtask

    initial begin
        bool_found_blk: begin end
    end

    initial begin
        bit found;
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        dif.en_i_div   = 1'b0;
        dif.dividend_i = '0;
        dif.divisor_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        //   dividend divisor  trunc   rounded  rem  dbz
        run(16'd65025, 8'd255, 16'd255,   16'd255,   8'd0,   1'b0);
        run(16'd1000,  8'd7,   16'd142,   16'd143,   8'd6,   1'b0);
        // outputs must hold in IDLE
        repeat (4) @(posedge clk);
        #1;
        chk("hold_quotient", {16'd0, dif.quotient_o}, {16'd0, pick_q(16'd142, 16'd143)});
        chk("hold_remainder", {24'd0, dif.remainder_o}, 32'd6);
        run(16'd100,   8'd0,   16'hFFFF,  16'hFFFF,  8'd0,   1'b1);
        run(16'd0,     8'd5,   16'd0,     16'd0,     8'd0,   1'b0);
        run(16'd65535, 8'd1,   16'd65535, 16'd65535, 8'd0,   1'b0);
        run(16'd12345, 8'd100, 16'd123,   16'd123,   8'd45,  1'b0);
        run(16'd255,   8'd16,  16'd15,    16'd16,    8'd15,  1'b0);
        run(16'd7,     8'd14,  16'd0,     16'd1,     8'd7,   1'b0);
        run(16'd65534, 8'd255, 16'd256,   16'd257,   8'd254, 1'b0);
        run(16'd65535, 8'd2,   16'd32767, 16'd32768, 8'd1,   1'b0);

        // en held through OP with changed operands: ignored until done falls
        @(negedge clk);
        dif.en_i_div   = 1'b1;
        dif.dividend_i = 16'd1000;
        dif.divisor_i  = 8'd7;
        @(posedge clk);
        #1;
        push_exp(16'd142, 16'd143, 8'd6, 1'b0);
        dif.dividend_i = 16'd50;
        dif.divisor_i  = 8'd2;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dif.div_done_o === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL b2b_first_done actual=0 required=1");
        end
        @(posedge clk);
        #1;
        push_exp(16'd25, 16'd25, 8'd0, 1'b0);
        dif.en_i_div = 1'b0;
        chk("b2b_busy", {31'd0, dif.busy_o}, 32'd1);
        wait_idle();

        // reset in the middle of an operation: no done pulse, outputs cleared
        @(negedge clk);
        dif.en_i_div   = 1'b1;
        dif.dividend_i = 16'd1234;
        dif.divisor_i  = 8'd5;
        @(posedge clk);
        #1;
        dif.en_i_div = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_done_busy", {31'd0, dif.busy_o}, 32'd0);

        run(16'd200, 8'd3, 16'd66, 16'd67, 8'd2, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case anything above stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
